// File: rtl/ex_mem_skid_pkg.sv
// Shared EX->MEM pipeline definitions: memory op codes, default widths,
// skid-buffer state encoding and occupancy decode.
package ex_mem_skid_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_REG_AW = 5;

    localparam logic [1:0] MEMRW_IDLE  = 2'b00;
    localparam logic [1:0] MEMRW_READ  = 2'b01;
    localparam logic [1:0] MEMRW_WRITE = 2'b10;

    localparam logic [DEF_DATA_W-1:0] ZERO_DATA     = '0;
    localparam logic [DEF_REG_AW-1:0] ZERO_REG_ADDR = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    function automatic logic [1:0] occ_of(input skid_state_t s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_skid_if.sv
// Valid/ready handshake bundle carrying the EX->MEM writeback and memory fields.
interface ex_mem_skid_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEMRW_W = 2
);
    logic               valid;
    logic               ready;
    logic [MEMRW_W-1:0] memrw;
    logic [ADDR_W-1:0]  memaddr;
    logic [DATA_W-1:0]  memdata;
    logic [DATA_W-1:0]  wdata;
    logic [REG_AW-1:0]  waddr;
    logic               we;

    modport master (
        output valid, memrw, memaddr, memdata, wdata, waddr, we,
        input  ready
    );

    modport slave (
        input  valid, memrw, memaddr, memdata, wdata, waddr, we,
        output ready
    );
endinterface

// File: rtl/ex_mem_skid_pipe_payload_reg.sv
// Enable-loaded payload register with asynchronous active-high reset to zero.
module pipe_payload_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline boundary: valid/ready handshake with a main register plus
// optional skid register, synchronous flush, bubble outputs when empty.
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned REG_AW  = DEF_REG_AW,
    parameter int unsigned MEMRW_W = 2,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    ex_mem_skid_if.slave       in_if,
    ex_mem_skid_if.master      out_if,
    output logic [1:0]         occupancy
);
    typedef struct packed {
        logic [MEMRW_W-1:0] memrw;
        logic [ADDR_W-1:0]  memaddr;
        logic [DATA_W-1:0]  memdata;
        logic [DATA_W-1:0]  wdata;
        logic [REG_AW-1:0]  waddr;
        logic               we;
    } payload_t;

    localparam int unsigned PL_W = $bits(payload_t);

    skid_state_t state_q, state_d;
    payload_t    in_pl, main_d, main_q, skid_q;
    logic        accept, drain;
    logic        load_main, load_skid, main_from_skid;

    assign in_pl  = '{memrw:   in_if.memrw,
                      memaddr: in_if.memaddr,
                      memdata: in_if.memdata,
                      wdata:   in_if.wdata,
                      waddr:   in_if.waddr,
                      we:      in_if.we};
    assign accept = in_if.valid & in_if.ready;
    assign drain  = out_if.valid & out_if.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (accept) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                // Older skid entry is promoted before any new input is taken.
                ST_TWO: if (drain) begin
                    state_d        = ST_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pl;

    pipe_payload_reg #(.W(PL_W)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (load_main),
        .d   (main_d),
        .q   (main_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic in_ready_q;

            pipe_payload_reg #(.W(PL_W)) u_skid (
                .clk (clk),
                .rst (rst),
                .en  (load_skid),
                .d   (in_pl),
                .q   (skid_q)
            );

            // Ready is taken straight from a flop so MEM back-pressure never reaches EX.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    in_ready_q <= 1'b1;
                else
                    in_ready_q <= (state_d != ST_TWO);
            end
            assign in_if.ready = in_ready_q;
        end else begin : g_single
            assign skid_q      = '0;
            assign in_if.ready = (state_q == ST_EMPTY) || out_if.ready;
        end
    endgenerate

    assign out_if.valid   = (state_q != ST_EMPTY);
    assign out_if.memrw   = out_if.valid ? main_q.memrw : MEMRW_W'(MEMRW_IDLE);
    assign out_if.we      = out_if.valid & main_q.we;
    assign out_if.memaddr = main_q.memaddr;
    assign out_if.memdata = main_q.memdata;
    assign out_if.wdata   = main_q.wdata;
    assign out_if.waddr   = main_q.waddr;
    assign occupancy      = occ_of(state_q);

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: SKID_EN=1 and SKID_EN=0 instances share one stimulus,
// each checked every cycle against a queue model plus directed literal checks.
module tb_ex_mem_skid;
    import ex_mem_skid_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  memrw = '0;
    logic [31:0] memaddr = '0;
    logic [31:0] memdata = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  waddr = '0;
    logic        we = 1'b0;
    logic [1:0]  occ1, occ0;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    ex_mem_skid_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .MEMRW_W(2)) in1 ();
    ex_mem_skid_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .MEMRW_W(2)) out1 ();
    ex_mem_skid_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .MEMRW_W(2)) in0 ();
    ex_mem_skid_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .MEMRW_W(2)) out0 ();

    assign in1.valid = in_valid;   assign in0.valid = in_valid;
    assign in1.memrw = memrw;      assign in0.memrw = memrw;
    assign in1.memaddr = memaddr;  assign in0.memaddr = memaddr;
    assign in1.memdata = memdata;  assign in0.memdata = memdata;
    assign in1.wdata = wdata;      assign in0.wdata = wdata;
    assign in1.waddr = waddr;      assign in0.waddr = waddr;
    assign in1.we = we;            assign in0.we = we;
    assign out1.ready = out_ready; assign out0.ready = out_ready;

    ex_mem_skid #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .MEMRW_W(2), .SKID_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_if(in1), .out_if(out1), .occupancy(occ1)
    );
    ex_mem_skid #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .MEMRW_W(2), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_if(in0), .out_if(out0), .occupancy(occ0)
    );

    typedef struct packed {
        logic [1:0]  memrw;
        logic [31:0] memaddr;
        logic [31:0] memdata;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        we;
    } pl_t;

    // Model: each instance is a FIFO of capacity 2 (skid) or 1 (single).
    pl_t q1[$];
    pl_t q0[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            pass_cnt++;
    endtask

    always @(posedge clk or posedge rst) begin
        bit acc1, drn1, acc0, drn0;
        pl_t cur;
        if (rst) begin
            q1.delete();
            q0.delete();
        end else if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            cur  = '{memrw, memaddr, memdata, wdata, waddr, we};
            acc1 = in_valid && (q1.size() < 2);
            drn1 = out_ready && (q1.size() > 0);
            acc0 = in_valid && ((q0.size() == 0) || out_ready);
            drn0 = out_ready && (q0.size() > 0);
            if (drn1) void'(q1.pop_front());
            if (acc1) q1.push_back(cur);
            if (drn0) void'(q0.pop_front());
            if (acc0) q0.push_back(cur);
        end
    end

    task automatic cmp(input string tag, input int sz, input pl_t head, input logic exp_rdy,
                       input logic rdy, input logic vld, input logic [1:0] occ, input pl_t act);
        chk({tag, "_in_ready"}, 128'(rdy), 128'(exp_rdy));
        chk({tag, "_out_valid"}, 128'(vld), 128'(sz > 0));
        chk({tag, "_occupancy"}, 128'(occ), 128'(sz));
        if (sz > 0) begin
            chk({tag, "_payload"}, 128'(act), 128'(head));
        end else begin
            chk({tag, "_bubble_memrw"}, 128'(act.memrw), 128'(MEMRW_IDLE));
            chk({tag, "_bubble_we"}, 128'(act.we), 128'(0));
        end
    endtask

    always @(negedge clk) begin
        pl_t h1, h0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        cmp("skid", q1.size(), h1, q1.size() < 2, in1.ready, out1.valid, occ1,
            '{out1.memrw, out1.memaddr, out1.memdata, out1.wdata, out1.waddr, out1.we});
        cmp("single", q0.size(), h0, (q0.size() == 0) || out_ready, in0.ready, out0.valid, occ0,
            '{out0.memrw, out0.memaddr, out0.memdata, out0.wdata, out0.waddr, out0.we});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [4:0] a, input logic [1:0] rw, input logic [31:0] ma);
        in_valid = 1'b1;
        waddr    = a;
        wdata    = 32'h1000 + 32'(a);
        memrw    = rw;
        memaddr  = ma;
        memdata  = 32'hD000 + 32'(a);
        we       = (rw != MEMRW_WRITE);
    endtask

    initial begin
        // Reset held while EX presents traffic.
        push(5'd9, MEMRW_READ, 32'h90);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 128'(out1.valid), 128'(0));
        chk("rst_memrw", 128'(out1.memrw), 128'(2'b00));
        chk("rst_we", 128'(out1.we), 128'(0));
        chk("rst_occ", 128'(occ1), 128'(0));
        chk("rst_in_ready1", 128'(in1.ready), 128'(1));
        chk("rst_in_ready0", 128'(in0.ready), 128'(1));
        in_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Streaming at full rate.
        for (int unsigned w = 1; w <= 8; w++) begin
            push(5'(w), MEMRW_READ, 32'(w * 4));
            chk("stream_in_ready", 128'(in1.ready), 128'(1));
            tick();
            chk("stream_waddr", 128'(out1.waddr), 128'(w));
            chk("stream_wdata", 128'(out1.wdata), 128'(32'h1000 + w));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_valid", 128'(out1.valid), 128'(0));

        // Back-pressure fills the skid entry.
        out_ready = 1'b0;
        push(5'd3, MEMRW_WRITE, 32'h10);
        tick();
        push(5'd4, MEMRW_READ, 32'h14);
        tick();
        in_valid = 1'b0;
        chk("bp_occ1", 128'(occ1), 128'(2));
        chk("bp_in_ready1", 128'(in1.ready), 128'(0));
        chk("bp_hold_a", 128'(out1.waddr), 128'(3));
        chk("bp_occ0", 128'(occ0), 128'(1));
        chk("bp_in_ready0", 128'(in0.ready), 128'(0));
        out_ready = 1'b1;
        tick();
        chk("bp_then_b", 128'(out1.waddr), 128'(4));
        tick();
        chk("bp_bubble_valid", 128'(out1.valid), 128'(0));
        chk("bp_bubble_memrw", 128'(out1.memrw), 128'(0));

        // Flush with a store presented the same cycle.
        out_ready = 1'b0;
        push(5'd5, MEMRW_READ, 32'h20);
        tick();
        push(5'd6, MEMRW_READ, 32'h24);
        tick();
        chk("fl_pre_occ", 128'(occ1), 128'(2));
        flush = 1'b1;
        push(5'd7, MEMRW_WRITE, 32'h40);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ1", 128'(occ1), 128'(0));
        chk("fl_valid1", 128'(out1.valid), 128'(0));
        chk("fl_memrw1", 128'(out1.memrw), 128'(MEMRW_IDLE));
        chk("fl_in_ready1", 128'(in1.ready), 128'(1));
        chk("fl_occ0", 128'(occ0), 128'(0));
        out_ready = 1'b1;
        tick();
        chk("fl_store_gone", 128'(out1.valid), 128'(0));

        // Single-entry replace-and-drain.
        out_ready = 1'b0;
        push(5'd7, MEMRW_READ, 32'h70);
        tick();
        chk("rd_full0", 128'(occ0), 128'(1));
        out_ready = 1'b1;
        push(5'd8, MEMRW_READ, 32'h80);
        #1;
        chk("rd_in_ready0", 128'(in0.ready), 128'(1));
        tick();
        in_valid = 1'b0;
        chk("rd_occ0", 128'(occ0), 128'(1));
        chk("rd_waddr0", 128'(out0.waddr), 128'(8));
        chk("rd_occ1", 128'(occ1), 128'(1));
        tick();

        // Asynchronous reset between edges with one entry held.
        out_ready = 1'b0;
        push(5'd10, MEMRW_READ, 32'hA0);
        tick();
        in_valid = 1'b0;
        chk("ar_pre_we", 128'(out1.we), 128'(1));
        rst = 1'b1;
        #1;
        chk("ar_we1", 128'(out1.we), 128'(0));
        chk("ar_valid1", 128'(out1.valid), 128'(0));
        chk("ar_we0", 128'(out0.we), 128'(0));
        tick();
        rst = 1'b0;
        tick();

        // Mixed pattern of stalls and gaps, covered by the per-cycle model check.
        for (int unsigned i = 0; i < 40; i++) begin
            out_ready = (i % 3) != 0;
            flush     = (i == 29);
            if ((i % 4) != 1)
                push(5'(i), (i % 2 == 0) ? MEMRW_READ : MEMRW_WRITE, 32'(i * 8));
            else
                in_valid = 1'b0;
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
Parametrised EX->MEM pipeline boundary with a valid/ready handshake and a two-entry skid buffer, so MEM back-pressure never forms a combinational path to EX. It carries the register writeback fields (wdata, waddr, we) and the memory-request fields (memrw, memaddr, memdata). Supports a synchronous flush for branch and exception squash. Whenever no valid entry is presented, outputs are forced to a bubble: memrw Idle, we disabled.

Parameters:
DATA_W, 32, width of wdata and memdata
ADDR_W, 32, width of memaddr
REG_AW, 5, width of register-file write address
MEMRW_W, 2, width of memory-operation code
SKID_EN, 1, 1 = two-entry skid buffer (full throughput, registered in_ready); 0 = single entry, in_ready = !full || out_ready

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage accepts this cycle
in_memrw  in  MEMRW_W  memory op from EX
in_memaddr  in  ADDR_W  memory address from EX
in_memdata  in  DATA_W  store data from EX
in_wdata  in  DATA_W  writeback data from EX
in_waddr  in  REG_AW  writeback register from EX
in_we  in  1  writeback enable from EX
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM consumes entry this cycle
out_memrw  out  MEMRW_W  memory op to MEM
out_memaddr  out  ADDR_W  address to MEM
out_memdata  out  DATA_W  store data to MEM
out_wdata  out  DATA_W  writeback data to MEM
out_waddr  out  REG_AW  writeback register to MEM
out_we  out  1  writeback enable to MEM
occupancy  out  2  entries held (0..2; max 1 when SKID_EN=0)

Behaviour:
- Reset (rst high, asynchronous): both entries invalid; all payload registers zero; memrw = MEMRW_IDLE; we = 0; out_valid = 0; occupancy = 0; in_ready = 1 (SKID_EN=1) or 1 (SKID_EN=0, empty).
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready, both on the rising clk edge.
- Latency: one cycle. An entry accepted at edge N appears on out_* after edge N when the main register is empty or draining.
- States (SKID_EN=1):
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: both valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept, no drain -> TWO; the new entry goes to skid.
  - ONE + accept + drain -> ONE; the new entry goes to main.
  - ONE + drain only -> EMPTY.
  - TWO + drain -> ONE; skid moves to main.
  - TWO never accepts, because in_ready = 0.
- in_ready (SKID_EN=1) = !skid_valid, driven from a flop only.
- Ordering is strictly FIFO: skid content always drains before newer input.
- Bubble rule: when out_valid = 0, out_memrw = MEMRW_IDLE and out_we = 0. Other out_* hold their last value, which is don't-care.
- Payload registers load only on accept; no enable toggling when idle.
- flush: all entries become invalid at the edge, and in_valid that cycle is discarded.
  - Flush has priority over accept and drain.
  - occupancy = 0 and in_ready = 1 the cycle after.
- Simultaneous accept + drain with occupancy = 1: throughput is 1 entry/cycle and occupancy stays 1.
- SKID_EN=0: single entry. Accept when empty or draining in the same cycle; in_ready is combinational from out_ready.
- Reset asserted mid-operation discards all held entries immediately and asynchronously; outputs go to bubble without waiting for a clock edge.

Decomposition:
- Shared package (pipeline defines):
  - MEMRW_IDLE = 2'b00, MEMRW_READ = 2'b01, MEMRW_WRITE = 2'b10.
  - ZERO_DATA, ZERO_REG_ADDR.
  - Default widths: DATA_W 32, ADDR_W 32, REG_AW 5.
- One packed payload bundle {memrw, memaddr, memdata, wdata, waddr, we} so the storage is a single vector.
- One natural sub-module: pipe_payload_reg, an enable-loaded, async-reset register of parametrised width, instantiated for main and skid.

Test Plan:
- Reset: hold rst during traffic -> out_valid = 0, out_memrw = 2'b00, out_we = 0, occupancy = 0, in_ready = 1.
- Streaming: out_ready = 1, push waddr 1..8 on consecutive cycles with wdata = 0x1000 + waddr -> each appears one cycle later, in order, with no in_ready deassertion.
- Back-pressure: out_ready = 0, push A (waddr 3) and B (waddr 4) -> occupancy = 2, in_ready = 0, output holds A. Raise out_ready -> A, then B, then bubble.
- Flush: with occupancy = 2, assert flush together with in_valid (store to memaddr 0x40) -> next cycle out_valid = 0, memrw = Idle, occupancy = 0; the store never reaches MEM.
- Mid-stream async reset: assert rst between clock edges with occupancy = 1 -> out_we = 0 immediately, before the next edge.
- SKID_EN=0 variant: full entry with out_ready = 1 and in_valid = 1 -> replace-and-drain in the same cycle, occupancy stays 1; with out_ready = 0 -> in_ready = 0.
